block_draw_sequencer: RTL and testbench
=======================================

// Module: block_draw_sequencer
// PURPOSE
//   Sequences all VGA adapter pixel writes for one moving block. On each game tick it
//   erases the SIZE x SIZE block at the old position, then draws it at the new position.
//   It also runs full-screen clears and is the sole owner of the adapter plot port.
//   Sits between the game control FSM/rate divider (tick, clear request) and the VGA adapter.
// PARAMETERS
//   X_W       8       x coordinate width
//   Y_W       7       y coordinate width
//   SIZE      4       block edge length in pixels (1..16)
//   SCREEN_W  160     visible width; pixels with x >= SCREEN_W are not plotted
//   SCREEN_H  120     visible height; pixels with y >= SCREEN_H are not plotted
//   BG_COL    3'b000  colour used for erase and clear
// PORTS
//   clk         in   1    clock
//   reset_n     in   1    synchronous, active-low reset
//   tick        in   1    one-cycle pulse: start erase+draw
//   clear_req   in   1    one-cycle pulse: clear whole screen to BG_COL
//   old_x/old_y in   X_W/Y_W  block origin to erase; sampled when tick is accepted
//   new_x/new_y in   X_W/Y_W  block origin to draw; sampled when tick is accepted
//   colour      in   3    draw colour; sampled when tick is accepted
//   vga_x       out  X_W  adapter pixel x
//   vga_y       out  Y_W  adapter pixel y
//   vga_colour  out  3    adapter pixel colour
//   vga_plot    out  1    adapter write enable
//   busy        out  1    high in every state except IDLE
//   done        out  1    one-cycle pulse at the end of each operation
//   overrun     out  1    sticky: a tick arrived while busy; cleared only by reset
// BEHAVIOUR
//   - Reset (reset_n=0 at an edge) from any state, including mid-operation:
//     state=IDLE; counters=0; vga_x/vga_y/vga_colour/vga_plot/busy/done/overrun=0;
//     pending clear dropped.
//   - States: IDLE, CLR, ERASE, DRAW, DONE.
//   - IDLE:
//     clear_req or pending clear -> CLR.
//     Otherwise tick -> ERASE; latch old/new coords and colour.
//     clear_req beats tick in the same cycle; that tick is dropped and sets overrun.
//   - ERASE/DRAW: one pixel per cycle from a latched base (old or new) plus offsets (cx,cy).
//     cx scans fastest, 0..SIZE-1, then cy. 16 cycles each for SIZE=4.
//     ERASE -> DRAW after pixel (SIZE-1,SIZE-1). DRAW -> DONE after its last pixel.
//   - CLR: scans x 0..SCREEN_W-1 fastest, then y 0..SCREEN_H-1, with BG_COL.
//     19200 cycles for the defaults; then -> DONE.
//   - DONE: done=1 for exactly one cycle, then -> IDLE.
//   - Outputs are combinational from state/counters; no added latency.
//     tick accepted at edge N: first ERASE pixel visible in cycle N+1, last DRAW pixel in
//     cycle N+2*SIZE*SIZE, done in cycle N+2*SIZE*SIZE+1, IDLE the cycle after.
//   - Coordinate arithmetic: sum = base + offset, computed 1 bit wider.
//     If sum >= SCREEN_W (x) or >= SCREEN_H (y): vga_plot=0 for that cycle, but the cycle
//     is still consumed. No wrap-around onto the opposite edge.
//   - vga_colour = BG_COL in ERASE/CLR; latched colour in DRAW; 0 in IDLE/DONE.
//     vga_plot=0 in IDLE/DONE.
//   - clear_req while busy: latched as pending (one deep). It is served on the IDLE cycle
//     after DONE; repeated requests merge.
//   - tick while busy (any non-IDLE state): ignored, overrun<=1. Latched coords stay stable.
//   - old == new coordinates: full erase then draw still performed.
// STRUCTURE
//   - Shared header vga_defs.vh: SCREEN_W/H defaults, colour constants (BLACK, WHITE, ...),
//     state encodings.
//   - Sub-module pixel_scanner (params XW,YW): 2-D counter with
//     start/enable/limit_x/limit_y, outputs cx/cy/last. One instance, reused by ERASE, DRAW
//     and CLR; limits are muxed by state.
//   - Top holds the FSM, coordinate latches, pending-clear flag, clipping adders and
//     output muxes.
// TESTING
//   1. Reset mid-DRAW (reset_n=0 one cycle) -> next cycle busy=0, vga_plot=0, overrun=0;
//      a later tick runs normally.
//   2. tick, old=(10,20), new=(11,20), colour=3'b100 -> 16 plots BG_COL at x10-13/y20-23,
//      cx fastest; then 16 plots colour 3'b100 at x11-14/y20-23; done in cycle N+33.
//   3. tick, new=(158,118) -> DRAW runs 16 cycles; plot=1 only for x158-159/y118-119
//      (4 pixels), 0 for the other 12.
//   4. clear_req and tick in the same IDLE cycle -> CLR runs 19200 cycles covering (0,0)..
//      (159,119) with BG_COL; overrun=1; no ERASE occurs.
//   5. clear_req during ERASE -> erase+draw completes, done; one idle cycle; CLR starts;
//      second done.
//   6. Second tick during DRAW -> ignored; overrun=1 and stays 1 until reset; drawn
//      coordinates come from the first tick.

Source files
------------

// File: rtl/block_draw_sequencer_pkg.sv
// rtl/block_draw_sequencer_pkg.sv - shared screen, colour and state definitions
//
// Purpose: screen-size defaults, 3-bit colour constants and the sequencer
//          state encoding, imported by the block draw sequencer files.
// Ports:   none (package).
package block_draw_sequencer_pkg;

  localparam int SCREEN_W_DEFAULT = 160;
  localparam int SCREEN_H_DEFAULT = 120;

  localparam logic [2:0] COL_BLACK   = 3'b000;
  localparam logic [2:0] COL_BLUE    = 3'b001;
  localparam logic [2:0] COL_GREEN   = 3'b010;
  localparam logic [2:0] COL_CYAN    = 3'b011;
  localparam logic [2:0] COL_RED     = 3'b100;
  localparam logic [2:0] COL_MAGENTA = 3'b101;
  localparam logic [2:0] COL_YELLOW  = 3'b110;
  localparam logic [2:0] COL_WHITE   = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_ERASE = 3'd2,
    S_DRAW  = 3'd3,
    S_DONE  = 3'd4
  } seq_state_t;

endpackage

// File: rtl/pixel_scanner.sv
// rtl/pixel_scanner.sv - 2-D pixel counter, x fastest then y
//
// Purpose: steps (cx,cy) over 0..limit_x by 0..limit_y, one point per enabled
//          cycle, and wraps back to (0,0) after the last point.
// Ports:
//   clk, reset_n       clock, synchronous active-low reset
//   start              force the counter back to (0,0)
//   enable             advance one point
//   limit_x, limit_y   highest cx / cy value of the current scan
//   cx, cy             current point
//   last               current point is (limit_x, limit_y)
module pixel_scanner #(
  parameter int XW = 8,
  parameter int YW = 7
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          enable,
  input  logic [XW-1:0] limit_x,
  input  logic [YW-1:0] limit_y,
  output logic [XW-1:0] cx,
  output logic [YW-1:0] cy,
  output logic          last
);

  logic last_x;
  logic last_y;

  assign last_x = (cx == limit_x);
  assign last_y = (cy == limit_y);
  assign last   = last_x && last_y;

  always_ff @(posedge clk) begin
    if (!reset_n || start) begin
      cx <= '0;
      cy <= '0;
    end else if (enable) begin
      if (last_x) begin
        cx <= '0;
        cy <= last_y ? '0 : cy + 1'b1;
      end else begin
        cx <= cx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/block_draw_sequencer.sv
// rtl/block_draw_sequencer.sv - erase/draw/clear sequencer owning the VGA plot port
//
// Purpose: on tick, erases the SIZE x SIZE block at the old origin, then draws it
//          at the new origin; on clear_req, fills the whole screen with BG_COL.
// Ports:
//   clk, reset_n                 clock, synchronous active-low reset
//   tick                         start erase+draw (coords/colour sampled on accept)
//   clear_req                    clear whole screen (merged pending flag while busy)
//   old_x, old_y, new_x, new_y   block origins to erase / draw
//   colour                       draw colour
//   vga_x, vga_y, vga_colour     adapter pixel address and colour
//   vga_plot                     adapter write enable
//   busy                         any state except IDLE
//   done                         one-cycle pulse at the end of each operation
//   overrun                      sticky: tick arrived and could not be accepted
module block_draw_sequencer
  import block_draw_sequencer_pkg::*;
#(
  parameter int         X_W      = 8,
  parameter int         Y_W      = 7,
  parameter int         SIZE     = 4,
  parameter int         SCREEN_W = SCREEN_W_DEFAULT,
  parameter int         SCREEN_H = SCREEN_H_DEFAULT,
  parameter logic [2:0] BG_COL   = COL_BLACK
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           tick,
  input  logic           clear_req,
  input  logic [X_W-1:0] old_x,
  input  logic [Y_W-1:0] old_y,
  input  logic [X_W-1:0] new_x,
  input  logic [Y_W-1:0] new_y,
  input  logic [2:0]     colour,
  output logic [X_W-1:0] vga_x,
  output logic [Y_W-1:0] vga_y,
  output logic [2:0]     vga_colour,
  output logic           vga_plot,
  output logic           busy,
  output logic           done,
  output logic           overrun
);

  localparam logic [X_W-1:0] BLK_LIM_X = X_W'(SIZE - 1);
  localparam logic [Y_W-1:0] BLK_LIM_Y = Y_W'(SIZE - 1);
  localparam logic [X_W-1:0] SCR_LIM_X = X_W'(SCREEN_W - 1);
  localparam logic [Y_W-1:0] SCR_LIM_Y = Y_W'(SCREEN_H - 1);
  localparam logic [X_W:0]   SCR_W_EXT = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0]   SCR_H_EXT = (Y_W+1)'(SCREEN_H);

  seq_state_t state;
  seq_state_t next_state;

  logic [X_W-1:0] old_x_q, new_x_q;
  logic [Y_W-1:0] old_y_q, new_y_q;
  logic [2:0]     colour_q;
  logic           clr_pending;

  logic           clr_wanted;
  logic           tick_accept;
  logic           scanning;
  logic           scan_start;
  logic [X_W-1:0] lim_x;
  logic [Y_W-1:0] lim_y;
  logic [X_W-1:0] cx;
  logic [Y_W-1:0] cy;
  logic           scan_last;

  logic [X_W-1:0] base_x;
  logic [Y_W-1:0] base_y;
  logic [X_W:0]   sum_x;
  logic [Y_W:0]   sum_y;

  // A clear (fresh or pending) always wins over a tick arriving in IDLE.
  assign clr_wanted  = clear_req || clr_pending;
  assign tick_accept = (state == S_IDLE) && tick && !clr_wanted;
  assign scanning    = (state == S_CLR) || (state == S_ERASE) || (state == S_DRAW);
  // Every scan ends by wrapping to (0,0); holding the counter in IDLE also
  // recovers cleanly after a reset that landed mid-scan.
  assign scan_start  = (state == S_IDLE);

  assign lim_x = (state == S_CLR) ? SCR_LIM_X : BLK_LIM_X;
  assign lim_y = (state == S_CLR) ? SCR_LIM_Y : BLK_LIM_Y;

  pixel_scanner #(
    .XW (X_W),
    .YW (Y_W)
  ) u_scanner (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (scan_start),
    .enable  (scanning),
    .limit_x (lim_x),
    .limit_y (lim_y),
    .cx      (cx),
    .cy      (cy),
    .last    (scan_last)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Coordinate latches, pending clear and overrun flag
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      old_x_q     <= '0;
      old_y_q     <= '0;
      new_x_q     <= '0;
      new_y_q     <= '0;
      colour_q    <= '0;
      clr_pending <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (tick_accept) begin
        old_x_q  <= old_x;
        old_y_q  <= old_y;
        new_x_q  <= new_x;
        new_y_q  <= new_y;
        colour_q <= colour;
      end
      // In IDLE any pending clear is consumed by the transition to CLR.
      if (state == S_IDLE) begin
        clr_pending <= 1'b0;
      end else if (clear_req) begin
        clr_pending <= 1'b1;
      end
      if (tick && !tick_accept) begin
        overrun <= 1'b1;
      end
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (clr_wanted) begin
          next_state = S_CLR;
        end else if (tick) begin
          next_state = S_ERASE;
        end
      end
      S_CLR:   if (scan_last) next_state = S_DONE;
      S_ERASE: if (scan_last) next_state = S_DRAW;
      S_DRAW:  if (scan_last) next_state = S_DONE;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Output logic: sums are one bit wider so off-screen pixels are suppressed
  // rather than wrapping onto the opposite edge.
  always_comb begin
    base_x     = '0;
    base_y     = '0;
    vga_colour = 3'b000;
    case (state)
      S_ERASE: begin
        base_x     = old_x_q;
        base_y     = old_y_q;
        vga_colour = BG_COL;
      end
      S_DRAW: begin
        base_x     = new_x_q;
        base_y     = new_y_q;
        vga_colour = colour_q;
      end
      S_CLR: begin
        vga_colour = BG_COL;
      end
      default: begin
        vga_colour = 3'b000;
      end
    endcase
    sum_x    = {1'b0, base_x} + {1'b0, cx};
    sum_y    = {1'b0, base_y} + {1'b0, cy};
    vga_plot = scanning && (sum_x < SCR_W_EXT) && (sum_y < SCR_H_EXT);
    vga_x    = scanning ? sum_x[X_W-1:0] : '0;
    vga_y    = scanning ? sum_y[Y_W-1:0] : '0;
    busy     = (state != S_IDLE);
    done     = (state == S_DONE);
  end

endmodule

// File: tb/tb_block_draw_sequencer.sv
// tb/tb_block_draw_sequencer.sv - directed self-checking bench for block_draw_sequencer
module tb_block_draw_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tick = 1'b0;
  logic       clear_req = 1'b0;
  logic [7:0] old_x = '0;
  logic [6:0] old_y = '0;
  logic [7:0] new_x = '0;
  logic [6:0] new_y = '0;
  logic [2:0] colour = '0;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       busy;
  logic       done;
  logic       overrun;

  int n_checks = 0;
  int n_errors = 0;

  block_draw_sequencer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .tick       (tick),
    .clear_req  (clear_req),
    .old_x      (old_x),
    .old_y      (old_y),
    .new_x      (new_x),
    .new_y      (new_y),
    .colour     (colour),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .busy       (busy),
    .done       (done),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle 1 ns past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pack(input int b, input int d, input int p,
                                       input int x, input int y, input int c);
    pack = {11'd0, b[0], d[0], p[0], x[7:0], y[6:0], c[2:0]};
  endfunction

  function automatic logic [31:0] observed();
    observed = pack(int'(busy), int'(done), int'(vga_plot),
                    vga_plot ? int'(vga_x) : 0, vga_plot ? int'(vga_y) : 0,
                    int'(vga_colour));
  endfunction

  // Accept a tick, check all 2*16 pixels and the done cycle. Optionally pulse a
  // second tick (with different coords) or a clear_req after pixel index inj_*.
  task automatic run_block(input string tag, input int ox, input int oy,
                           input int nx, input int ny, input int col,
                           input int tick_at, input int clr_at);
    int bx, by, sx, sy, ep, ec, j;
    old_x = 8'(ox); old_y = 7'(oy); new_x = 8'(nx); new_y = 7'(ny); colour = 3'(col);
    tick = 1'b1;
    step();
    tick = 1'b0;
    old_x = 8'd77; old_y = 7'd77; new_x = 8'd5; new_y = 7'd5; colour = 3'b111;
    for (int i = 0; i < 32; i++) begin
      j  = i % 16;
      bx = (i < 16) ? ox : nx;
      by = (i < 16) ? oy : ny;
      sx = bx + j % 4;
      sy = by + j / 4;
      ep = (sx < 160 && sy < 120) ? 1 : 0;
      ec = (i < 16) ? 0 : col;
      check($sformatf("%s pix%0d", tag, i), observed(),
            pack(1, 0, ep, ep ? sx : 0, ep ? sy : 0, ec));
      if (i == tick_at) begin
        new_x = 8'd0; new_y = 7'd0; tick = 1'b1;
      end
      if (i == clr_at) clear_req = 1'b1;
      step();
      tick = 1'b0;
      clear_req = 1'b0;
    end
    check({tag, " done"}, observed(), pack(1, 1, 0, 0, 0, 0));
    step();
  endtask

  // Check a full-screen clear starting at the current cycle, then its done cycle.
  task automatic run_clr(input string tag);
    for (int i = 0; i < 19200; i++) begin
      check($sformatf("%s clr%0d", tag, i), observed(), pack(1, 0, 1, i % 160, i / 160, 0));
      step();
    end
    check({tag, " done"}, observed(), pack(1, 1, 0, 0, 0, 0));
    step();
  endtask

  initial begin
    reset_n = 1'b0;
    step();
    step();
    check("reset outputs", observed(), pack(0, 0, 0, 0, 0, 0));
    check("reset raw xy", {17'd0, vga_x, vga_y}, 32'd0);
    check("reset overrun", {31'd0, overrun}, 32'd0);
    reset_n = 1'b1;
    step();
    check("idle after reset", observed(), pack(0, 0, 0, 0, 0, 0));

    // Erase at (10,20), draw at (11,20) in red.
    run_block("t2", 10, 20, 11, 20, 4, -1, -1);
    check("t2 idle", observed(), pack(0, 0, 0, 0, 0, 0));
    check("t2 overrun", {31'd0, overrun}, 32'd0);

    // Block drawn at the bottom-right corner: only 4 of 16 draw pixels plotted.
    run_block("t3", 0, 0, 158, 118, 2, -1, -1);
    check("t3 overrun", {31'd0, overrun}, 32'd0);

    // Same origin for erase and draw still performs both passes.
    run_block("same", 40, 50, 40, 50, 7, -1, -1);

    // Second tick during DRAW is ignored and sets sticky overrun.
    run_block("t6", 30, 40, 50, 60, 1, 20, -1);
    check("t6 overrun", {31'd0, overrun}, 32'd1);
    step();
    step();
    check("t6 overrun sticky", {31'd0, overrun}, 32'd1);

    // Reset in the middle of DRAW.
    old_x = 8'd60; old_y = 7'd60; new_x = 8'd61; new_y = 7'd61; colour = 3'b011;
    tick = 1'b1;
    step();
    tick = 1'b0;
    for (int i = 0; i < 20; i++) step();
    check("t1 in draw", {29'd0, busy, vga_plot, vga_colour == 3'b011}, 32'd7);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check("t1 after reset", observed(), pack(0, 0, 0, 0, 0, 0));
    check("t1 overrun cleared", {31'd0, overrun}, 32'd0);
    step();

    // clear_req during ERASE is held until the erase+draw finishes.
    run_block("t5", 70, 80, 71, 80, 5, -1, 3);
    check("t5 idle gap", observed(), pack(0, 0, 0, 0, 0, 0));
    step();
    run_clr("t5");
    check("t5 idle", observed(), pack(0, 0, 0, 0, 0, 0));
    check("t5 overrun", {31'd0, overrun}, 32'd0);

    // clear_req and tick together: clear wins, tick dropped, overrun set.
    old_x = 8'd10; old_y = 7'd20; new_x = 8'd11; new_y = 7'd20; colour = 3'b100;
    clear_req = 1'b1;
    tick = 1'b1;
    step();
    clear_req = 1'b0;
    tick = 1'b0;
    check("t4 overrun", {31'd0, overrun}, 32'd1);
    run_clr("t4");
    check("t4 idle", observed(), pack(0, 0, 0, 0, 0, 0));
    step();
    check("t4 no erase", observed(), pack(0, 0, 0, 0, 0, 0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
